// File: rtl/mprj_pad_cfg_sequencer.sv
// Pad-ring configuration sequencer: holds one config word per pad and, on request, resets the
// external control chain, shifts every word out serially and strobes the chain load.
module mprj_pad_cfg_sequencer #(
  parameter int unsigned         NUM_PADS  = 38,
  parameter int unsigned         CFG_BITS  = 13,
  parameter int unsigned         CLK_DIV   = 2,
  parameter logic [CFG_BITS-1:0] CFG_RESET = CFG_BITS'(13'h0403),
  parameter int unsigned         AW        = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                clock,
  input  logic                resetb,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_wdata,
  output logic [CFG_BITS-1:0] cfg_rdata,
  output logic                cfg_wr_ignored,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                serial_clock,
  output logic                serial_data,
  output logic                serial_load,
  output logic                serial_resetn
);

  localparam int unsigned BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [AW-1:0] PadMax    = AW'(NUM_PADS - 1);
  localparam logic [BW-1:0] BitMax    = BW'(CFG_BITS - 1);
  localparam logic [DW-1:0] DivMax    = DW'(CLK_DIV - 1);
  localparam logic [AW:0]   NumPadsEx = (AW + 1)'(NUM_PADS);

  typedef enum logic [2:0] {StIdle, StChainRst, StShift, StLoad, StDone} state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic                phase_q, phase_d;
  logic [AW-1:0]       pad_q, pad_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [CFG_BITS-1:0] cfg_q [NUM_PADS];

  logic sclk_q, sclk_d;
  logic sdata_q, sdata_d;
  logic sload_q, sload_d;
  logic srstn_q, srstn_d;
  logic done_q, done_d;
  logic ign_q, ign_d;

  logic addr_ok, wr_ok, div_last, cur_bit;

  assign addr_ok  = {1'b0, cfg_addr} < NumPadsEx;
  assign wr_ok    = cfg_we && (state_q == StIdle) && addr_ok;
  assign ign_d    = cfg_we && !((state_q == StIdle) && addr_ok);
  assign div_last = (div_q == DivMax);
  assign cur_bit  = cfg_q[pad_q][bit_q];

  assign cfg_rdata = addr_ok ? cfg_q[cfg_addr] : '0;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < int'(NUM_PADS); i++) cfg_q[i] <= CFG_RESET;
    end else if (wr_ok) begin
      cfg_q[cfg_addr] <= cfg_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    phase_d = phase_q;
    pad_d   = pad_q;
    bit_d   = bit_q;
    sclk_d  = 1'b0;
    sdata_d = 1'b0;
    sload_d = 1'b0;
    srstn_d = 1'b1;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        div_d = '0;
        if (start) begin
          state_d = StChainRst;
          pad_d   = PadMax;
          bit_d   = BitMax;
          phase_d = 1'b0;
        end
      end
      StChainRst: begin
        srstn_d = 1'b0;
        if (div_last) begin
          div_d   = '0;
          state_d = StShift;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StShift: begin
        sclk_d  = phase_q;
        sdata_d = cur_bit;
        if (!div_last) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // End of a high phase: advance to the next bit, MSB-first, top pad first.
            phase_d = 1'b0;
            if (bit_q != '0) begin
              bit_d = bit_q - 1'b1;
            end else begin
              bit_d = BitMax;
              if (pad_q == '0) state_d = StLoad;
              else             pad_d   = pad_q - 1'b1;
            end
          end
        end
      end
      StLoad: begin
        sload_d = 1'b1;
        if (div_last) begin
          div_d   = '0;
          state_d = StDone;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Chain outputs are registered copies of what the current state asks for.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= StIdle;
      div_q   <= '0;
      phase_q <= 1'b0;
      pad_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      sload_q <= 1'b0;
      srstn_q <= 1'b0;
      done_q  <= 1'b0;
      ign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      pad_q   <= pad_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      sload_q <= sload_d;
      srstn_q <= srstn_d;
      done_q  <= done_d;
      ign_q   <= ign_d;
    end
  end

  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign serial_clock   = sclk_q;
  assign serial_data    = sdata_q;
  assign serial_load    = sload_q;
  assign serial_resetn  = srstn_q;
  assign cfg_wr_ignored = ign_q;

endmodule

// File: tb/tb_mprj_pad_cfg_sequencer.sv
// Bench for mprj_pad_cfg_sequencer: a small (4x3, div 1) and a full-size (38x13, div 2) instance
// checked against a word-array model and an expected serial bitstream.
module tb_mprj_pad_cfg_sequencer;

  logic        clock = 1'b0;
  logic        resetb, we, start, sel;
  logic [5:0]  addr;
  logic [12:0] wdata;

  logic [2:0]  s_rdata;
  logic        s_ign, s_busy, s_done, s_sclk, s_sdata, s_sload, s_srst;
  logic [12:0] b_rdata;
  logic        b_ign, b_busy, b_done, b_sclk, b_sdata, b_sload, b_srst;

  logic [12:0] m_rdata;
  logic        m_ign, m_busy, m_done, m_sclk, m_sdata, m_sload, m_srst;

  logic [12:0] model [2][38];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clock = ~clock;

  mprj_pad_cfg_sequencer #(
    .NUM_PADS(4), .CFG_BITS(3), .CLK_DIV(1), .CFG_RESET(3'b101)
  ) u_small (
    .clock(clock), .resetb(resetb), .cfg_we(we & ~sel), .cfg_addr(addr[1:0]),
    .cfg_wdata(wdata[2:0]), .cfg_rdata(s_rdata), .cfg_wr_ignored(s_ign),
    .start(start & ~sel), .busy(s_busy), .done(s_done), .serial_clock(s_sclk),
    .serial_data(s_sdata), .serial_load(s_sload), .serial_resetn(s_srst)
  );

  mprj_pad_cfg_sequencer #(
    .NUM_PADS(38), .CFG_BITS(13), .CLK_DIV(2), .CFG_RESET(13'h0403)
  ) u_big (
    .clock(clock), .resetb(resetb), .cfg_we(we & sel), .cfg_addr(addr),
    .cfg_wdata(wdata), .cfg_rdata(b_rdata), .cfg_wr_ignored(b_ign),
    .start(start & sel), .busy(b_busy), .done(b_done), .serial_clock(b_sclk),
    .serial_data(b_sdata), .serial_load(b_sload), .serial_resetn(b_srst)
  );

  assign m_rdata = sel ? b_rdata : {10'd0, s_rdata};
  assign m_ign   = sel ? b_ign   : s_ign;
  assign m_busy  = sel ? b_busy  : s_busy;
  assign m_done  = sel ? b_done  : s_done;
  assign m_sclk  = sel ? b_sclk  : s_sclk;
  assign m_sdata = sel ? b_sdata : s_sdata;
  assign m_sload = sel ? b_sload : s_sload;
  assign m_srst  = sel ? b_srst  : s_srst;

  function automatic int np_of();
    return sel ? 38 : 4;
  endfunction

  function automatic int cb_of();
    return sel ? 13 : 3;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 38; p++) begin
      model[0][p] = 13'd5;
      model[1][p] = 13'h0403;
    end
  endtask

  task automatic write_word(input int a, input logic [12:0] d);
    bit exp_ok;
    exp_ok = a < np_of();
    we = 1'b1; addr = 6'(a); wdata = d;
    @(posedge clock); #1;
    we = 1'b0;
    if (exp_ok) model[sel][a] = d & 13'((1 << cb_of()) - 1);
    vectors++;
    if (m_ign !== !exp_ok) begin
      miscompares++;
      $display("FAIL wr_ignored addr=%0d: got %b want %b", a, m_ign, !exp_ok);
    end
    vectors++;
    if (m_rdata !== (exp_ok ? model[sel][a] : 13'd0)) begin
      miscompares++;
      $display("FAIL readback addr=%0d: got %h want %h", a, m_rdata,
               exp_ok ? model[sel][a] : 13'd0);
    end
  endtask

  task automatic check_all_words(input string tag);
    for (int p = 0; p < np_of(); p++) begin
      addr = 6'(p); #1;
      vectors++;
      if (m_rdata !== model[sel][p]) begin
        miscompares++;
        $display("FAIL %s word[%0d]: got %h want %h", tag, p, m_rdata, model[sel][p]);
      end
    end
  endtask

  // Starts a chain update and watches it cycle by cycle. poke_k: cycle for a write+start while
  // busy (-1 = none); abort_k: cycle at which resetb is pulled mid-shift (-1 = none).
  task automatic run_chain(input int cd, input int nb, input int poke_k, input int abort_k);
    bit exp_q[$];
    bit got_q[$];
    int lat, k, done_k, done_cnt, rst_low, load_cnt, phase_err, busy_err, ign_cnt;
    int hi_run, lo_run, n_rise, bad_idx;
    bit prev_sclk, last_bit, aborted;
    for (int p = np_of() - 1; p >= 0; p--)
      for (int b = cb_of() - 1; b >= 0; b--) exp_q.push_back(model[sel][p][b]);
    lat = 2 * cd + 2 * cd * nb + 1;
    done_k = -1; done_cnt = 0; rst_low = 0; load_cnt = 0; phase_err = 0; busy_err = 0;
    ign_cnt = 0; hi_run = 0; lo_run = 0; n_rise = 0; prev_sclk = 1'b0; last_bit = 1'b0;
    aborted = 1'b0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; we = 1'b0;
    k = 0;
    while (k <= lat + 6 && !aborted) begin
      if (m_busy !== (k < lat)) busy_err++;
      if (m_done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (!m_srst) rst_low++;
      if (m_sload) load_cnt++;
      if (m_ign) ign_cnt++;
      if (m_sclk && !prev_sclk) begin
        if (n_rise > 0 && lo_run != cd) phase_err++;
        got_q.push_back(m_sdata);
        last_bit = m_sdata; n_rise++; hi_run = 1;
      end else if (m_sclk) begin
        hi_run++;
        if (m_sdata !== last_bit) phase_err++;
      end else if (prev_sclk) begin
        if (hi_run != cd) phase_err++;
        lo_run = 1;
      end else begin
        lo_run++;
      end
      prev_sclk = m_sclk;
      if (poke_k >= 0 && k == poke_k + 1) begin
        vectors++;
        if (m_ign !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_write_pulse: got %b want 1", m_ign);
        end
        we = 1'b0; start = 1'b0;
      end
      if (k == poke_k) begin
        we = 1'b1; addr = 6'd2; wdata = ~model[sel][2]; start = 1'b1;
      end
      if (k == abort_k) begin
        #2 resetb = 1'b0; #1;
        vectors++;
        if ({m_sclk, m_sdata, m_sload, m_srst, m_busy, m_done, m_ign} !== 7'b0) begin
          miscompares++;
          $display("FAIL async_reset outputs: got %b want 0000000",
                   {m_sclk, m_sdata, m_sload, m_srst, m_busy, m_done, m_ign});
        end
        vectors++;
        if (load_cnt !== 0 || n_rise !== 6) begin
          miscompares++;
          $display("FAIL abort_progress: got load=%0d rises=%0d want load=0 rises=6",
                   load_cnt, n_rise);
        end
        aborted = 1'b1;
        @(posedge clock); @(posedge clock); #1;
        resetb = 1'b1;
        model_reset();
      end else begin
        @(posedge clock); #1;
        k++;
      end
    end
    if (!aborted) begin
      bad_idx = -1;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        if (bad_idx < 0 && got_q[i] !== exp_q[i]) bad_idx = i;
      vectors++;
      if (got_q.size() != exp_q.size() || bad_idx >= 0) begin
        miscompares++;
        $display("FAIL stream: got %0d bits (first bad %0d) want %0d bits", got_q.size(),
                 bad_idx, exp_q.size());
      end
      vectors++;
      if (done_k !== lat || done_cnt !== 1) begin
        miscompares++;
        $display("FAIL done_timing: got cycle %0d x%0d want cycle %0d x1", done_k, done_cnt, lat);
      end
      vectors++;
      if (rst_low !== cd) begin
        miscompares++;
        $display("FAIL chain_reset_width: got %0d want %0d", rst_low, cd);
      end
      vectors++;
      if (load_cnt !== cd) begin
        miscompares++;
        $display("FAIL load_width: got %0d want %0d", load_cnt, cd);
      end
      vectors++;
      if (phase_err !== 0) begin
        miscompares++;
        $display("FAIL clock_phases: got %0d bad phases want 0", phase_err);
      end
      vectors++;
      if (busy_err !== 0) begin
        miscompares++;
        $display("FAIL busy_window: got %0d bad cycles want 0", busy_err);
      end
      vectors++;
      if (ign_cnt !== ((poke_k >= 0) ? 1 : 0)) begin
        miscompares++;
        $display("FAIL wr_ignored_count: got %0d want %0d", ign_cnt, (poke_k >= 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0; we = 1'b0; start = 1'b0; addr = '0; wdata = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      vectors++;
      if ({m_sclk, m_sdata, m_sload, m_srst, m_busy, m_done, m_ign} !== 7'b0) begin
        miscompares++;
        $display("FAIL reset_outputs dut%0d: got %b want 0000000", s,
                 {m_sclk, m_sdata, m_sload, m_srst, m_busy, m_done, m_ign});
      end
    end
    resetb = 1'b1; #1;
    vectors++;
    if (s_srst !== 1'b0 || b_srst !== 1'b0) begin
      miscompares++;
      $display("FAIL resetn_before_edge: got %b%b want 00", s_srst, b_srst);
    end
    @(posedge clock); #1;
    vectors++;
    if (s_srst !== 1'b1 || b_srst !== 1'b1) begin
      miscompares++;
      $display("FAIL resetn_after_edge: got %b%b want 11", s_srst, b_srst);
    end
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      check_all_words("reset_value");
    end
  endtask

  task automatic test_directed();
    sel = 1'b0;
    write_word(3, 13'b110);
    write_word(2, 13'b001);
    write_word(1, 13'b011);
    write_word(0, 13'b100);
    run_chain(1, 12, -1, -1);
  endtask

  task automatic test_random_small();
    sel = 1'b0;
    repeat (3) begin
      for (int p = 0; p < 4; p++) write_word(p, 13'($urandom));
      run_chain(1, 12, -1, -1);
    end
  endtask

  task automatic test_busy_poke();
    sel = 1'b0;
    for (int p = 0; p < 4; p++) write_word(p, 13'($urandom));
    run_chain(1, 12, 5, -1);
    check_all_words("after_busy_write");
  endtask

  task automatic test_bad_addr();
    sel = 1'b1;
    write_word(40, 13'($urandom));
    write_word(63, 13'($urandom));
    write_word(37, 13'($urandom));
    @(posedge clock); #1;
    vectors++;
    if (m_ign !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_ignored_idle: got %b want 0", m_ign);
    end
  endtask

  task automatic test_mid_reset();
    sel = 1'b0;
    for (int p = 0; p < 4; p++) write_word(p, 13'($urandom));
    run_chain(1, 12, -1, 14);
    check_all_words("after_abort");
    sel = 1'b1;
    check_all_words("after_abort_big");
    sel = 1'b0;
    write_word(1, 13'($urandom));
    run_chain(1, 12, -1, -1);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    for (int r = 0; r < 2; r++) begin
      // Write lands on the same edge that accepts start and must be shifted out.
      we = 1'b1; addr = 6'(r * 3); wdata = 13'($urandom);
      model[0][r * 3] = wdata & 13'h7;
      run_chain(1, 12, -1, -1);
    end
  endtask

  task automatic test_big();
    sel = 1'b1;
    for (int p = 0; p < 38; p++) write_word(p, 13'($urandom));
    run_chain(2, 494, -1, -1);
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_directed();
    test_random_small();
    test_busy_poke();
    test_bad_addr();
    test_mid_reset();
    test_back_to_back();
    test_big();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
